// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit -- instruction-fetch sequencer for the Hack CPU.
//
// Sits between the program counter and decode. It steps the PC, issues
// single-outstanding reads to instruction ROM at the current PC, and
// buffers the returned words (with their fetch address) in a small FIFO.
// A jump redirect reloads the PC and discards everything in flight.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a ROM word arriving into an empty FIFO while decode is
//   ready goes straight to the decode outputs in the ack cycle.
//   When undefined, every word passes through the FIFO (1-cycle latency).
//
// Parameters:
//   DEPTH  instruction FIFO entries (>= 1)
//   AW     ROM address width (<= 16), rom_addr = pc[AW-1:0]
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   pc             current PC register value
//   pc_inc         PC increment strobe
//   pc_load        PC load strobe (redirect)
//   pc_in          PC load value
//   rom_req        ROM read request (held until rom_ack)
//   rom_addr       ROM read address
//   rom_ack        ROM response valid
//   rom_data       ROM response word
//   redirect       taken-jump pulse from execute
//   redirect_addr  jump target
//   inst_valid     decode-side valid
//   inst_ready     decode-side ready
//   inst           instruction word at FIFO head
//   inst_pc        fetch address of the head word

module hack_fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   pc,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [15:0]   pc_in,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [15:0]   rom_data,
  input  logic          redirect,
  input  logic [15:0]   redirect_addr,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [15:0]   inst,
  output logic [15:0]   inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [15:0]     r_mem_data [DEPTH];
  logic [15:0]     r_mem_pc   [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_hold_addr;

  logic            w_ack_take;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_count_after;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  // Datapath control: accept, bypass, push, pop.
  always_comb begin
    w_ack_take = (r_state == S_REQ) && rom_ack && !redirect;
    w_empty    = (r_count == '0);
`ifdef FETCH_BYPASS_EN
    w_bypass   = w_ack_take && w_empty && inst_ready;
`else
    w_bypass   = 1'b0;
`endif
    w_push        = w_ack_take && !w_bypass;
    inst_valid    = !redirect && (!w_empty || w_bypass);
    w_pop         = inst_valid && inst_ready && !w_empty;
    w_count_after = r_count + CW'(w_push) - CW'(w_pop);
  end

  // PC and ROM side outputs. Reset gating keeps pc_load/pc_in quiet while
  // reset is held even if a stray redirect pulse arrives.
  always_comb begin
    pc_inc   = w_ack_take;
    pc_load  = redirect && reset;
    pc_in    = pc_load ? redirect_addr : '0;
    rom_req  = (r_state == S_REQ) || (r_state == S_FLUSH);
    // PC has already moved to the jump target while the old read is still
    // outstanding, so FLUSH presents the captured address instead.
    rom_addr = (r_state == S_FLUSH) ? r_hold_addr : pc[AW-1:0];
  end

  // Decode side outputs.
  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (w_bypass) begin
      inst    = rom_data;
      inst_pc = pc;
    end else if (!w_empty) begin
      inst    = r_mem_data[r_rd_ptr];
      inst_pc = r_mem_pc[r_rd_ptr];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!redirect && (r_count < CW'(DEPTH))) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          w_state_nxt = rom_ack ? S_IDLE : S_FLUSH;
        end else if (rom_ack) begin
          w_state_nxt = (w_count_after < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_FLUSH: begin
        // The dropped response ends the flush even if another redirect
        // lands in the same cycle; PC simply reloads again.
        if (rom_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_hold_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_REQ) r_hold_addr <= pc[AW-1:0];
      if (redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_after;
        if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      end
    end
  end

  // FIFO storage; contents are only visible through the count, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= pc;
    end
  end

endmodule
